cmp_search_ctrl: RTL and testbench

- Sequential counterpart to the team's combinational magnitude comparator: drives the comparator's B operand and consumes its A_gt_B / A_lt_B / A_eq_B flags.
- On a start request it runs a binary search to find the unknown value on the comparator's A input.
- Reports the value found, the number of probes used, and an error flag if the comparator flags are inconsistent.
- Sits beside the comparator in lab-level datapaths (threshold finders, SAR-style converters).

---
 rtl/cmp_search_ctrl_pkg.sv | 32 +++
 rtl/cmp_search_ctrl.sv | 147 ++++++++++++++
 tb/tb_cmp_search_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cmp_search_ctrl_pkg.sv
// Shared types for the comparator search controller.
//   state_e      : controller FSM states
//   flag_e       : decoded comparator verdict for the current guess
//   decode_flags : maps the raw A_gt_B / A_lt_B / A_eq_B flags to a verdict;
//                  anything other than exactly one flag set is BAD.
package cmp_search_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    FLG_EQ,
    FLG_GT,
    FLG_LT,
    FLG_BAD
  } flag_e;

  function automatic flag_e decode_flags(input logic gt, input logic lt, input logic eq);
    flag_e f;
    case ({gt, lt, eq})
      3'b100:  f = FLG_GT;
      3'b010:  f = FLG_LT;
      3'b001:  f = FLG_EQ;
      default: f = FLG_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cmp_search_ctrl.sv
// Binary-search controller wrapped around an external combinational
// magnitude comparator. It drives the comparator's B operand (guess) and
// narrows [lo, hi] from the comparator flags until A is matched.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin a search (only looked at in IDLE)
//   cmp_gt/lt/eq    comparator flags for the guess driven last cycle
//   guess           registered B operand
//   busy            high while probing
//   done            one-cycle pulse when a search ends
//   found, err      outcome of the last search, held until next start
//   result          matched value when found, else 0
//   probes          probes evaluated in the last or current search
module cmp_search_ctrl
  import cmp_search_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW   = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    probes
);

  localparam logic [WIDTH:0]   HI_INIT = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ONE_W1  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] G_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] G_MIN   = '0;
  localparam logic [CW-1:0]    ONE_CW  = {{(CW-1){1'b0}}, 1'b1};

  // Midpoint of two WIDTH+1-bit bounds; the sum needs one extra bit.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [WIDTH+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  state_e           state, state_n;
  logic [WIDTH:0]   lo, lo_n, hi, hi_n;
  logic [WIDTH-1:0] guess_n, result_n;
  logic [CW-1:0]    probes_n;
  logic             found_n, err_n;

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned; without these defaults the block would infer latches.
  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    guess_n  = guess;
    result_n = result;
    probes_n = probes;
    found_n  = found;
    err_n    = err;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_PROBE;
          lo_n     = '0;
          hi_n     = HI_INIT;
          guess_n  = midpoint('0, HI_INIT);
          probes_n = '0;
          found_n  = 1'b0;
          err_n    = 1'b0;
          result_n = '0;
        end
      end
      ST_PROBE: begin
        probes_n = probes + ONE_CW;
        case (decode_flags(cmp_gt, cmp_lt, cmp_eq))
          FLG_BAD: begin
            state_n = ST_DONE;
            err_n   = 1'b1;
            found_n = 1'b0;
          end
          FLG_EQ: begin
            state_n  = ST_DONE;
            result_n = guess;
            found_n  = 1'b1;
          end
          FLG_GT: begin
            if (guess == G_MAX) begin
              state_n = ST_DONE;
            end else begin
              lo_n    = {1'b0, guess} + ONE_W1;
              guess_n = midpoint(lo_n, hi);
              // Only reachable with inconsistent (but one-hot) flags.
              if (lo_n > hi) state_n = ST_DONE;
            end
          end
          FLG_LT: begin
            if (guess == G_MIN) begin
              state_n = ST_DONE;
            end else begin
              hi_n    = {1'b0, guess} - ONE_W1;
              guess_n = midpoint(lo, hi_n);
              if (lo > hi_n) state_n = ST_DONE;
            end
          end
          default: state_n = ST_DONE;
        endcase
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      lo     <= '0;
      hi     <= HI_INIT;
      guess  <= '0;
      result <= '0;
      probes <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      result <= result_n;
      probes <= probes_n;
      found  <= found_n;
      err    <= err_n;
    end
  end

  // Decoded straight from the state register, so both drop with reset.
  assign busy = (state == ST_PROBE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl. A behavioural 4-bit comparator
// (A = target, B = guess) closes the loop; force_bad / force_lt override
// its flags for the error and no-match scenarios.
module tb_cmp_search_ctrl;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 2);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cmp_gt, cmp_lt, cmp_eq;
  logic [WIDTH-1:0] guess;
  logic             busy, done, found, err;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    probes;

  logic [WIDTH-1:0] target;
  logic             force_bad;
  logic             force_lt;

  int n_vec = 0;
  int n_err = 0;

  // Observations from the most recent run_search.
  logic [WIDTH-1:0] obs_guess [16];
  int               obs_n;
  int               obs_done;
  bit               obs_timeout;

  always #5 clk = ~clk;

  assign cmp_gt = force_bad ? 1'b1 : force_lt ? 1'b0 : (target > guess);
  assign cmp_lt = force_bad ? 1'b1 : force_lt ? 1'b1 : (target < guess);
  assign cmp_eq = (force_bad || force_lt) ? 1'b0 : (target == guess);

  cmp_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .probes (probes)
  );

  // mode 0: normal, 1: bad flags on 2nd probe, 2: cmp_lt forced high with a
  // stray start pulse during the 2nd probe. Returns one cycle after done.
  task automatic run_search(input int mode);
    obs_n = 0; obs_done = 0; obs_timeout = 1'b1;
    force_lt = (mode == 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (busy && obs_n < 16) begin
        obs_guess[obs_n] = guess;
        obs_n++;
      end
      force_bad = busy && (mode == 1) && (obs_n == 2);
      start     = busy && (mode == 2) && (obs_n == 2);
      if (done) obs_done++;
      if (obs_done > 0 && !done && !busy) begin
        obs_timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    force_bad = 1'b0;
    force_lt  = 1'b0;
    start     = 1'b0;
    n_vec++;
    if (obs_timeout) begin
      n_err++;
      $display("FAIL timeout: no done pulse within 24 cycles (probes=%0d)", probes);
    end
  endtask

  task automatic check_outcome(input string name, input logic e_found, input logic e_err,
                               input logic [WIDTH-1:0] e_result, input int e_probes,
                               input logic [WIDTH-1:0] e_g [5]);
    n_vec++;
    if (found !== e_found) begin n_err++; $display("FAIL %s found: got %b want %b", name, found, e_found); end
    n_vec++;
    if (err !== e_err) begin n_err++; $display("FAIL %s err: got %b want %b", name, err, e_err); end
    n_vec++;
    if (result !== e_result) begin n_err++; $display("FAIL %s result: got %0d want %0d", name, result, e_result); end
    n_vec++;
    if (probes !== CW'(e_probes)) begin n_err++; $display("FAIL %s probes: got %0d want %0d", name, probes, e_probes); end
    n_vec++;
    if (obs_n !== e_probes) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", name, obs_n, e_probes); end
    n_vec++;
    if (obs_done !== 1) begin n_err++; $display("FAIL %s done_pulses: got %0d want 1", name, obs_done); end
    for (int i = 0; i < e_probes && i < obs_n && i < 5; i++) begin
      n_vec++;
      if (obs_guess[i] !== e_g[i]) begin
        n_err++;
        $display("FAIL %s guess[%0d]: got %0d want %0d", name, i, obs_guess[i], e_g[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; target = '0; force_bad = 1'b0; force_lt = 1'b0;
    #12;
    n_vec++;
    if ({guess, result, probes, busy, done, found, err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: guess=%0d result=%0d probes=%0d busy=%b done=%b found=%b err=%b want all 0",
               guess, result, probes, busy, done, found, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_guess();
    logic [WIDTH-1:0] g [5] = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    target = 4'd7;
    run_search(0);
    check_outcome("target7", 1'b1, 1'b0, 4'd7, 1, g);
  endtask

  task automatic test_low_edge();
    logic [WIDTH-1:0] g [5] = '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0};
    target = 4'd0;
    run_search(0);
    check_outcome("target0", 1'b1, 1'b0, 4'd0, 4, g);
  endtask

  task automatic test_worst_case();
    logic [WIDTH-1:0] g [5] = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
    target = 4'd15;
    run_search(0);
    check_outcome("target15", 1'b1, 1'b0, 4'd15, 5, g);
  endtask

  task automatic test_bad_flags();
    logic [WIDTH-1:0] g [5] = '{4'd7, 4'd3, 4'd0, 4'd0, 4'd0};
    target = 4'd5;
    run_search(1);
    check_outcome("bad_flags", 1'b0, 1'b1, 4'd0, 2, g);
  endtask

  task automatic test_no_match_ignore_start();
    logic [WIDTH-1:0] g [5] = '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0};
    target = 4'd6;
    run_search(2);
    check_outcome("lt_forced", 1'b0, 1'b0, 4'd0, 4, g);
    // The stray start must not have queued a second search.
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL queued_start busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] g [5] = '{4'd7, 4'd11, 4'd9, 4'd0, 4'd0};
    int busy_seen = 0;
    int done_seen = 0;
    target = 4'd9;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8 && busy_seen < 3; c++) begin
      if (busy) busy_seen++;
      if (busy_seen < 3) @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({guess, result, probes, busy, done, found, err} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: guess=%0d result=%0d probes=%0d busy=%b done=%b found=%b err=%b want all 0",
               guess, result, probes, busy, done, found, err);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    @(negedge clk);
    if (done) done_seen++;
    n_vec++;
    if (done_seen !== 0) begin n_err++; $display("FAIL midreset_done: got %0d pulses want 0", done_seen); end
    run_search(0);
    check_outcome("after_reset", 1'b1, 1'b0, 4'd9, 3, g);
  endtask

  initial begin
    test_reset();
    test_first_guess();
    test_low_edge();
    test_worst_case();
    test_bad_flags();
    test_no_match_ignore_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
